// File: rtl/bcd2bin_seq.sv
// Sequential BCD-to-binary converter (reverse double dabble), one shift per clock.
// Valid/ready handshake on both sides; latency is W cycles from accept to out_valid.
module bcd2bin_seq #(
  parameter int D = 4,
  parameter int W = 14
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [4*D-1:0] bcd,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [W-1:0]   bin,
  output logic           err
);

  localparam int CW = (W > 1) ? $clog2(W) : 1;

  if ((2 ** W) <= (10 ** D - 1)) begin : g_width_check
    $error("bcd2bin_seq: W too small to hold 10^D - 1");
  end

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t          r_state;
  state_t          w_next_state;
  logic [4*D-1:0]  r_work;
  logic [W-1:0]    r_result;
  logic [CW-1:0]   r_count;
  logic [W-1:0]    r_bin;
  logic            r_err;
  logic [4*D-1:0]  w_work_shifted;
  logic [4*D-1:0]  w_work_next;
  logic [W-1:0]    w_result_next;
  logic            w_last_step;

  // Subtract 3 from every nibble >= 8; nibbles are independent (no borrow).
  function automatic logic [4*D-1:0] correct_nibbles(input logic [4*D-1:0] v);
    logic [4*D-1:0] res;
    logic [3:0]     nib;
    res = '0;
    for (int i = 0; i < D; i++) begin
      nib = v[4*i +: 4];
      if (nib >= 4'd8) begin
        res[4*i +: 4] = nib - 4'd3;
      end else begin
        res[4*i +: 4] = nib;
      end
    end
    return res;
  endfunction

  function automatic logic has_bad_digit(input logic [4*D-1:0] v);
    logic bad;
    bad = 1'b0;
    for (int i = 0; i < D; i++) begin
      if (v[4*i +: 4] > 4'd9) begin
        bad = 1'b1;
      end else begin
        bad = bad;
      end
    end
    return bad;
  endfunction

  assign w_work_shifted = {1'b0, r_work[4*D-1:1]};
  assign w_result_next  = {r_work[0], r_result[W-1:1]};
  assign w_work_next    = correct_nibbles(w_work_shifted);
  assign w_last_step    = (r_count == CW'(W - 1));

  assign in_ready  = (r_state == S_IDLE);
  assign out_valid = (r_state == S_DONE);
  assign bin       = r_bin;
  assign err       = r_err;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state decode
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE: begin
        if (in_valid) begin
          w_next_state = S_RUN;
        end else begin
          w_next_state = S_IDLE;
        end
      end
      S_RUN: begin
        if (w_last_step) begin
          w_next_state = S_DONE;
        end else begin
          w_next_state = S_RUN;
        end
      end
      S_DONE: begin
        if (out_ready) begin
          w_next_state = S_IDLE;
        end else begin
          w_next_state = S_DONE;
        end
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  // Datapath: load on accept, shift/correct each RUN step, capture masked result on the last step
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_work   <= '0;
      r_result <= '0;
      r_count  <= '0;
      r_bin    <= '0;
      r_err    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_work   <= bcd;
            r_result <= '0;
            r_count  <= '0;
            r_bin    <= '0;
            r_err    <= has_bad_digit(bcd);
          end
        end
        S_RUN: begin
          r_work   <= w_work_next;
          r_result <= w_result_next;
          r_count  <= r_count + CW'(1);
          if (w_last_step) begin
            // Invalid input still runs the full latency; only the output is masked.
            r_bin <= r_err ? '0 : w_result_next;
          end
        end
        S_DONE: begin
          r_bin <= r_bin;
        end
        default: begin
          r_work <= r_work;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bcd2bin_seq.sv
// Self-checking bench for bcd2bin_seq: directed cases with literal expectations plus
// randomized traffic compared every cycle against a latency-level behavioural model.
module tb_bcd2bin_seq;

  localparam int D = 4;
  localparam int W = 14;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           in_valid;
  logic           in_ready;
  logic [4*D-1:0] bcd;
  logic           out_valid;
  logic           out_ready;
  logic [W-1:0]   bin;
  logic           err;

  int n_checks = 0;
  int n_err    = 0;
  int cyc      = 0;

  bcd2bin_seq #(.D(D), .W(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .bcd       (bcd),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .bin       (bin),
    .err       (err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: decimal value of the digits, zero when any digit is not BCD.
  function automatic logic ref_err(input logic [4*D-1:0] v);
    logic e;
    e = 1'b0;
    for (int i = 0; i < D; i++) if (v[4*i +: 4] > 4'd9) e = 1'b1;
    return e;
  endfunction

  function automatic int ref_bin(input logic [4*D-1:0] v);
    int s;
    int p;
    s = 0;
    p = 1;
    for (int i = 0; i < D; i++) begin
      s = s + int'(v[4*i +: 4]) * p;
      p = p * 10;
    end
    return ref_err(v) ? 0 : s;
  endfunction

  // Model: 0 = idle, 1 = converting (m_left cycles to go), 2 = result held
  int          m_phase = 0;
  int          m_left  = 0;
  int          m_bin   = 0;
  logic        m_err   = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_phase <= 0;
      m_left  <= 0;
      m_bin   <= 0;
      m_err   <= 1'b0;
    end else begin
      case (m_phase)
        0: if (in_valid) begin
          m_phase <= 1;
          m_left  <= W;
          m_bin   <= ref_bin(bcd);
          m_err   <= ref_err(bcd);
        end
        1: begin
          m_left <= m_left - 1;
          if (m_left == 1) m_phase <= 2;
        end
        2: if (out_ready) m_phase <= 0;
        default: m_phase <= 0;
      endcase
    end
  end

  always @(negedge clk) begin
    chk("in_ready", {31'd0, in_ready}, {31'd0, (m_phase == 0)});
    chk("out_valid", {31'd0, out_valid}, {31'd0, (m_phase == 2)});
    if (m_phase == 2) begin
      chk("bin", {18'd0, bin}, m_bin);
      chk("err", {31'd0, err}, {31'd0, m_err});
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present a word and return the cycle number of the accepting edge (in_valid left high).
  task automatic accept(input logic [4*D-1:0] w, output int c);
    int n;
    in_valid = 1'b1;
    bcd      = w;
    n        = 0;
    while (!in_ready && n < 60) begin
      step();
      n++;
    end
    if (!in_ready) chk("accept_timeout", 32'd0, 32'd1);
    step();
    c = cyc;
  endtask

  task automatic wait_out(output int lat);
    lat = 0;
    while (!out_valid && lat < 60) begin
      step();
      lat++;
    end
    if (!out_valid) chk("out_valid_timeout", 32'd0, 32'd1);
  endtask

  function automatic logic [4*D-1:0] gen_bcd();
    logic [4*D-1:0] v;
    int r;
    int k;
    v = '0;
    for (int i = 0; i < D; i++) v[4*i +: 4] = 4'($urandom_range(0, 9));
    r = int'($urandom_range(0, 9));
    if (r == 0) begin
      k = int'($urandom_range(0, D - 1));
      v[4*k +: 4] = 4'($urandom_range(10, 15));
    end else if (r == 1) begin
      v = 16'h9999;
    end else if (r == 2) begin
      v = 16'h0000;
    end
    return v;
  endfunction

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0;
    int c1;
    int lat;
    logic hit;
    rst_n     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    bcd       = '0;
    #1 rst_n  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_bin", {18'd0, bin}, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);
    rst_n = 1'b1;
    step();

    // Full-scale value and latency
    out_ready = 1'b1;
    accept(16'h9999, c0);
    in_valid = 1'b0;
    wait_out(lat);
    chk("lat_9999", lat, 32'd14);
    chk("bin_9999", {18'd0, bin}, 32'd9999);
    chk("err_9999", {31'd0, err}, 32'd0);
    step();
    chk("in_ready_after_hs", {31'd0, in_ready}, 32'd1);
    chk("out_valid_after_hs", {31'd0, out_valid}, 32'd0);

    // Back-to-back with in_valid held: accepts spaced W+2 apart
    accept(16'h0000, c0);
    bcd = 16'h1234;
    wait_out(lat);
    chk("bin_0000", {18'd0, bin}, 32'd0);
    accept(16'h1234, c1);
    in_valid = 1'b0;
    chk("accept_spacing", c1 - c0, 32'd16);
    wait_out(lat);
    chk("bin_1234", {18'd0, bin}, 32'd1234);
    step();

    // Invalid digit: fixed latency, masked output
    accept(16'h12A4, c0);
    in_valid = 1'b0;
    wait_out(lat);
    chk("lat_12A4", lat, 32'd14);
    chk("err_12A4", {31'd0, err}, 32'd1);
    chk("bin_12A4", {18'd0, bin}, 32'd0);
    step();
    accept(16'h0042, c0);
    in_valid = 1'b0;
    wait_out(lat);
    chk("err_0042", {31'd0, err}, 32'd0);
    chk("bin_0042", {18'd0, bin}, 32'd42);
    step();

    // Backpressure
    out_ready = 1'b0;
    accept(16'h0500, c0);
    in_valid = 1'b0;
    wait_out(lat);
    for (int i = 0; i < 10; i++) begin
      chk("bp_bin", {18'd0, bin}, 32'd500);
      chk("bp_out_valid", {31'd0, out_valid}, 32'd1);
      chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
      step();
    end
    out_ready = 1'b1;
    step();
    chk("bp_release_in_ready", {31'd0, in_ready}, 32'd1);
    chk("bp_release_out_valid", {31'd0, out_valid}, 32'd0);

    // Asynchronous reset mid-conversion
    accept(16'h8765, c0);
    in_valid = 1'b0;
    repeat (7) step();
    #2 rst_n = 1'b0;
    #1;
    chk("arst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("arst_bin", {18'd0, bin}, 32'd0);
    chk("arst_err", {31'd0, err}, 32'd0);
    chk("arst_in_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk);
    #1 rst_n = 1'b1;
    accept(16'h0001, c0);
    in_valid = 1'b0;
    wait_out(lat);
    chk("lat_0001", lat, 32'd14);
    chk("bin_0001", {18'd0, bin}, 32'd1);
    step();

    // Randomized traffic, checked every cycle by the model compare process
    in_valid = 1'b0;
    for (int i = 0; i < 20000; i++) begin
      if (!in_valid && $urandom_range(0, 2) == 0) begin
        in_valid = 1'b1;
        bcd      = gen_bcd();
      end
      out_ready = ($urandom_range(0, 3) != 0);
      hit = in_valid && in_ready;
      step();
      if (hit) in_valid = 1'b0;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (20) step();

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
